// File: rtl/perceptron_train_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_train_ctrl_pkg
// Purpose  : Shared types and constants for the perceptron training sequencer:
//            FSM state encoding, delta width/encoding, activation encoding and
//            the delta computation helper.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package perceptron_train_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_ACC  = 3'd2,
        ST_WAIT = 3'd3,
        ST_ACT  = 3'd4,
        ST_UPD  = 3'd5,
        ST_NEXT = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    localparam int DELTA_W = 2;

    // Step activation: 1 only for a strictly positive accumulator.
    localparam logic ACT_POS  = 1'b1;
    localparam logic ACT_ZERO = 1'b0;

    // Two's complement delta encodings.
    localparam logic [DELTA_W-1:0] DELTA_ZERO = 2'b00;
    localparam logic [DELTA_W-1:0] DELTA_POS  = 2'b01;
    localparam logic [DELTA_W-1:0] DELTA_NEG  = 2'b11;

    // delta = label - act, restricted to {-1,0,+1}.
    function automatic logic [DELTA_W-1:0] calc_delta(input logic lbl, input logic act);
        logic [DELTA_W-1:0] d;
        d = DELTA_ZERO;
        if (lbl && !act)
            d = DELTA_POS;
        else if (!lbl && act)
            d = DELTA_NEG;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_train_ctrl
// Purpose  : Training sequencer for a perceptron datapath. Drives a shared MAC
//            through N_FEAT features per sample and N_SAMP samples per epoch,
//            evaluates the step activation, and issues per-feature weight
//            update strobes. Repeats epochs until a zero-error epoch occurs or
//            MAX_EPOCH epochs have completed.
// Ports    : clk, rst_n (sync, active low), start (pulse)
//            mac_acc (signed accumulator), label (target for samp_idx)
//            mac_clr / mac_en / w_upd : mutually exclusive datapath strobes
//            samp_idx / feat_idx      : sample-store and weight addresses
//            delta                    : signed update, valid with w_upd
//            act_out, busy, done, converged, epoch : status
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_train_ctrl
    import perceptron_train_ctrl_pkg::*;
#(
    parameter  int N_FEAT    = 2,
    parameter  int N_SAMP    = 3,
    parameter  int MAX_EPOCH = 16,
    parameter  int ACC_W     = 8,
    localparam int FEAT_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
    localparam int SAMP_W    = (N_SAMP > 1) ? $clog2(N_SAMP) : 1,
    localparam int EPOCH_W   = $clog2(MAX_EPOCH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ACC_W-1:0]   mac_acc,
    input  logic               label,
    output logic               mac_clr,
    output logic               mac_en,
    output logic [SAMP_W-1:0]  samp_idx,
    output logic [FEAT_W-1:0]  feat_idx,
    output logic               w_upd,
    output logic [DELTA_W-1:0] delta,
    output logic               act_out,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch
);

    // Error counter only needs to distinguish zero from non-zero, but it is
    // sized to hold a full epoch's worth of errors and saturates there.
    localparam int ERR_W = $clog2(N_SAMP + 1);

    localparam logic [FEAT_W-1:0]  c_feat_last = FEAT_W'(N_FEAT - 1);
    localparam logic [SAMP_W-1:0]  c_samp_last = SAMP_W'(N_SAMP - 1);
    localparam logic [EPOCH_W-1:0] c_epoch_max = EPOCH_W'(MAX_EPOCH);
    localparam logic [ERR_W-1:0]   c_err_max   = {ERR_W{1'b1}};

    state_t               r_state,  w_state_nxt;
    logic [FEAT_W-1:0]    r_feat,   w_feat_nxt;
    logic [SAMP_W-1:0]    r_samp,   w_samp_nxt;
    logic [EPOCH_W-1:0]   r_epoch,  w_epoch_nxt;
    logic [ERR_W-1:0]     r_err,    w_err_nxt;
    logic                 r_act,    w_act_nxt;
    logic [DELTA_W-1:0]   r_delta,  w_delta_nxt;
    logic                 r_conv,   w_conv_nxt;

    logic                 w_act_now;
    logic [DELTA_W-1:0]   w_delta_now;
    logic [EPOCH_W-1:0]   w_epoch_inc;

    // Strictly positive: sign bit clear and not zero (0 and -128 both give 0).
    assign w_act_now   = (!mac_acc[ACC_W-1] && (mac_acc != '0)) ? ACT_POS : ACT_ZERO;
    assign w_delta_now = calc_delta(label, w_act_now);
    assign w_epoch_inc = r_epoch + EPOCH_W'(1);

    // ------------------------------------------------------------------
    // State and counter register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_feat  <= '0;
            r_samp  <= '0;
            r_epoch <= '0;
            r_err   <= '0;
            r_act   <= 1'b0;
            r_delta <= DELTA_ZERO;
            r_conv  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_feat  <= w_feat_nxt;
            r_samp  <= w_samp_nxt;
            r_epoch <= w_epoch_nxt;
            r_err   <= w_err_nxt;
            r_act   <= w_act_nxt;
            r_delta <= w_delta_nxt;
            r_conv  <= w_conv_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_feat_nxt  = r_feat;
        w_samp_nxt  = r_samp;
        w_epoch_nxt = r_epoch;
        w_err_nxt   = r_err;
        w_act_nxt   = r_act;
        w_delta_nxt = r_delta;
        w_conv_nxt  = r_conv;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_CLR;
                    w_samp_nxt  = '0;
                    w_epoch_nxt = '0;
                    w_err_nxt   = '0;
                    w_conv_nxt  = 1'b0;
                end
            end
            ST_CLR: begin
                w_state_nxt = ST_ACC;
                w_feat_nxt  = '0;
            end
            ST_ACC: begin
                if (r_feat == c_feat_last)
                    w_state_nxt = ST_WAIT;
                else
                    w_feat_nxt = r_feat + FEAT_W'(1);
            end
            ST_WAIT: begin
                w_state_nxt = ST_ACT;
            end
            ST_ACT: begin
                w_act_nxt   = w_act_now;
                w_delta_nxt = w_delta_now;
                if (w_delta_now != DELTA_ZERO) begin
                    w_state_nxt = ST_UPD;
                    w_feat_nxt  = '0;
                    if (r_err != c_err_max)
                        w_err_nxt = r_err + ERR_W'(1);
                end else begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_UPD: begin
                if (r_feat == c_feat_last)
                    w_state_nxt = ST_NEXT;
                else
                    w_feat_nxt = r_feat + FEAT_W'(1);
            end
            ST_NEXT: begin
                if (r_samp != c_samp_last) begin
                    w_samp_nxt  = r_samp + SAMP_W'(1);
                    w_state_nxt = ST_CLR;
                end else begin
                    w_epoch_nxt = w_epoch_inc;
                    if (r_err == '0) begin
                        w_state_nxt = ST_DONE;
                        w_conv_nxt  = 1'b1;
                    end else if (w_epoch_inc == c_epoch_max) begin
                        w_state_nxt = ST_DONE;
                        w_conv_nxt  = 1'b0;
                    end else begin
                        w_samp_nxt  = '0;
                        w_err_nxt   = '0;
                        w_state_nxt = ST_CLR;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state register only, so strobes are
    // one-hot by construction and drop immediately on reset.
    // ------------------------------------------------------------------
    assign mac_clr   = (r_state == ST_CLR);
    assign mac_en    = (r_state == ST_ACC);
    assign w_upd     = (r_state == ST_UPD);
    assign delta     = (r_state == ST_UPD) ? r_delta : DELTA_ZERO;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign converged = r_conv;
    assign act_out   = r_act;
    assign epoch     = r_epoch;
    assign samp_idx  = r_samp;
    assign feat_idx  = r_feat;

endmodule
`default_nettype wire
